lab8_soc_sysid_checker: RTL

Avalon-MM read master that sits on the lab8 SoC fabric opposite the system-ID slave. On a start pulse it reads the ID word (address 0) and then the timestamp word (address 1), compares both against build-time expectations, and reports pass/fail. It retries if a read stalls and reports a timeout if the retries run out. Boot logic uses it to refuse to release the CPU against a mismatched bitstream/software pairing.

---
 rtl/lab8_soc_sysid_pkg.sv | 20 ++
 rtl/lab8_soc_sysid_watchdog.sv | 45 ++++
 rtl/lab8_soc_sysid_checker.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/lab8_soc_sysid_pkg.sv
// Shared types and constants for the lab8 system-ID checker.
package lab8_soc_sysid_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ID,
      ST_WAIT_ID,
      ST_RD_TS,
      ST_WAIT_TS,
      ST_DONE
   } sysid_chk_state_t;

   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;

   function automatic logic txn_active(input sysid_chk_state_t s);
      return s inside {ST_RD_ID, ST_WAIT_ID, ST_RD_TS, ST_WAIT_TS};
   endfunction

endpackage

// File: rtl/lab8_soc_sysid_watchdog.sv
// Per-read cycle counter: clear loads cycle 1 of a transaction, expired is high
// during the cycle whose count equals TIMEOUT_CYCLES.
module lab8_soc_sysid_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] ONE   = CW'(1);

   logic [CW-1:0] count_q, count_d;
   logic          expired_q, expired_d;

   // Counting stops once the limit is reached so the counter never wraps.
   always_comb begin
      count_d   = count_q;
      expired_d = expired_q;
      if (clear) begin
         count_d   = ONE;
         expired_d = (LIMIT == ONE);
      end else if (run && !expired_q) begin
         count_d   = count_q + ONE;
         expired_d = (count_d == LIMIT);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q   <= '0;
         expired_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         expired_q <= expired_d;
      end
   end

   assign expired = expired_q;

endmodule

// File: rtl/lab8_soc_sysid_checker.sv
// Avalon-MM read master that fetches the system-ID and timestamp words and
// compares them against build-time values, with per-read timeout and retry.
module lab8_soc_sysid_checker
   import lab8_soc_sysid_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1445297666,
   parameter int unsigned TIMEOUT_CYCLES     = 255,
   parameter int unsigned MAX_RETRIES        = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic        avm_readdatavalid,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   localparam int unsigned RW = $clog2(MAX_RETRIES + 2);
   localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRIES);

   sysid_chk_state_t state_q;
   logic             read_q, addr_q, busy_q, done_q;
   logic             id_ok_q, ts_ok_q, timeout_q;
   logic [31:0]      id_value_q, ts_value_q;
   logic [RW-1:0]    retry_q;

   logic expired, in_txn, data_hit, timed_out, can_retry, wd_clear;

   // Data arriving in the limit cycle takes priority over the timeout.
   always_comb begin
      in_txn    = txn_active(state_q);
      data_hit  = avm_readdatavalid &&
                  ((state_q == ST_WAIT_ID) || (state_q == ST_WAIT_TS));
      timed_out = in_txn && expired && !data_hit;
      can_retry = (retry_q < RETRY_LIM);
      wd_clear  = ((state_q == ST_IDLE) && start) ||
                  (timed_out && can_retry) ||
                  ((state_q == ST_WAIT_ID) && avm_readdatavalid);
   end

   lab8_soc_sysid_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clock  (clock),
      .reset  (reset),
      .clear  (wd_clear),
      .run    (in_txn),
      .expired(expired)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         read_q     <= 1'b0;
         addr_q     <= SYSID_ADDR_ID;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         id_ok_q    <= 1'b0;
         ts_ok_q    <= 1'b0;
         timeout_q  <= 1'b0;
         id_value_q <= '0;
         ts_value_q <= '0;
         retry_q    <= '0;
      end else begin
         done_q <= 1'b0;
         if (timed_out) begin
            if (can_retry) begin
               retry_q <= retry_q + RW'(1);
               state_q <= ST_RD_ID;
               read_q  <= 1'b1;
               addr_q  <= SYSID_ADDR_ID;
            end else begin
               state_q   <= ST_DONE;
               read_q    <= 1'b0;
               done_q    <= 1'b1;
               timeout_q <= 1'b1;
               id_ok_q   <= 1'b0;
               ts_ok_q   <= 1'b0;
            end
         end else begin
            unique case (state_q)
               ST_IDLE: if (start) begin
                  state_q   <= ST_RD_ID;
                  read_q    <= 1'b1;
                  addr_q    <= SYSID_ADDR_ID;
                  busy_q    <= 1'b1;
                  id_ok_q   <= 1'b0;
                  ts_ok_q   <= 1'b0;
                  timeout_q <= 1'b0;
                  retry_q   <= '0;
               end
               ST_RD_ID: if (!avm_waitrequest) begin
                  state_q <= ST_WAIT_ID;
                  read_q  <= 1'b0;
               end
               ST_WAIT_ID: if (avm_readdatavalid) begin
                  id_value_q <= avm_readdata;
                  state_q    <= ST_RD_TS;
                  read_q     <= 1'b1;
                  addr_q     <= SYSID_ADDR_TS;
               end
               ST_RD_TS: if (!avm_waitrequest) begin
                  state_q <= ST_WAIT_TS;
                  read_q  <= 1'b0;
               end
               ST_WAIT_TS: if (avm_readdatavalid) begin
                  ts_value_q <= avm_readdata;
                  id_ok_q    <= (id_value_q == EXPECTED_ID);
                  ts_ok_q    <= (avm_readdata == EXPECTED_TIMESTAMP);
                  done_q     <= 1'b1;
                  state_q    <= ST_DONE;
               end
               ST_DONE: begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign avm_address = addr_q;
   assign avm_read    = read_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign id_ok       = id_ok_q;
   assign ts_ok       = ts_ok_q;
   assign timeout     = timeout_q;
   assign id_value    = id_value_q;
   assign ts_value    = ts_value_q;

endmodule
